// File: rtl/corrector_error.sv
// SECDED Hamming(7,4) error corrector stage: classifies, fixes and extracts data,
// registers it behind a valid/ready handshake and counts error events.
module corrector_error #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       palabra_rx,
  input  logic [3:0]       pos_error,
  input  logic             clr_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       palabra_corr,
  output logic [3:0]       dato_corr,
  output logic [1:0]       estado_err,
  output logic [CNT_W-1:0] cnt_simple,
  output logic [CNT_W-1:0] cnt_doble
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0] e;
  logic       eg;
  logic       accept;
  logic [7:0] fix;
  logic [1:0] est;
  logic       simple_ev;
  logic       doble_ev;

  assign e        = pos_error[2:0];
  assign eg       = pos_error[3];
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    fix = palabra_rx;
    est = 2'b11;
    unique case (1'b1)
      (e == 3'd0 && !eg): begin
        est = 2'b00;
      end
      (e != 3'd0 && eg): begin
        fix = palabra_rx ^ (8'd1 << (e - 3'd1));
        est = 2'b01;
      end
      (e == 3'd0 && eg): begin
        fix = palabra_rx ^ 8'h80;
        est = 2'b10;
      end
      default: begin
        est = 2'b11;
      end
    endcase
  end

  // 01 and 10 both count as a single (recoverable) event
  assign simple_ev = accept && (est[1] ^ est[0]);
  assign doble_ev  = accept && (&est);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      palabra_corr <= '0;
      dato_corr    <= '0;
      estado_err   <= '0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      palabra_corr <= fix;
      dato_corr    <= {fix[6], fix[5], fix[4], fix[2]};
      estado_err   <= est;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cnt_simple <= '0;
      cnt_doble  <= '0;
    end else begin
      if (simple_ev && cnt_simple != CNT_MAX)
        cnt_simple <= cnt_simple + 1'b1;
      if (doble_ev && cnt_doble != CNT_MAX)
        cnt_doble <= cnt_doble + 1'b1;
    end
  end

endmodule

// File: tb/tb_corrector_error.sv
// Bench for corrector_error: directed spec vectors plus randomized traffic
// against a behavioural model; a CNT_W=2 copy exercises counter saturation.
module tb_corrector_error;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] palabra_rx = '0;
  logic [3:0] pos_error = '0;
  logic       clr_cnt = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready, out_valid;
  logic [7:0] palabra_corr;
  logic [3:0] dato_corr;
  logic [1:0] estado_err;
  logic [7:0] cnt_simple, cnt_doble;

  logic       s_in_ready, s_out_valid;
  logic [7:0] s_palabra_corr;
  logic [3:0] s_dato_corr;
  logic [1:0] s_estado_err;
  logic [1:0] s_cnt_simple, s_cnt_doble;

  int n_pass = 0;
  int n_tot  = 0;

  logic       m_valid = 1'b0;
  logic [7:0] m_word = '0;
  logic [3:0] m_dato = '0;
  logic [1:0] m_est = '0;
  int         m_cs = 0;
  int         m_cd = 0;

  corrector_error #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .palabra_rx(palabra_rx), .pos_error(pos_error), .clr_cnt(clr_cnt),
    .out_valid(out_valid), .out_ready(out_ready),
    .palabra_corr(palabra_corr), .dato_corr(dato_corr),
    .estado_err(estado_err), .cnt_simple(cnt_simple), .cnt_doble(cnt_doble)
  );

  corrector_error #(.CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .palabra_rx(palabra_rx), .pos_error(pos_error), .clr_cnt(clr_cnt),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .palabra_corr(s_palabra_corr), .dato_corr(s_dato_corr),
    .estado_err(s_estado_err), .cnt_simple(s_cnt_simple),
    .cnt_doble(s_cnt_doble)
  );

  always #5 clk = ~clk;

  logic [30:0] got_big;
  logic [18:0] got_small;
  assign got_big = {out_valid, palabra_corr, dato_corr, estado_err,
                    cnt_simple, cnt_doble};
  assign got_small = {s_out_valid, s_palabra_corr, s_dato_corr,
                      s_estado_err, s_cnt_simple, s_cnt_doble};

  function automatic logic [7:0] sat8(int c);
    return (c > 255) ? 8'd255 : c[7:0];
  endfunction

  function automatic logic [1:0] sat2(int c);
    return (c > 3) ? 2'd3 : c[1:0];
  endfunction

  function automatic logic [30:0] exp_big();
    return {m_valid, m_word, m_dato, m_est, sat8(m_cs), sat8(m_cd)};
  endfunction

  function automatic logic [18:0] exp_small();
    return {m_valid, m_word, m_dato, m_est, sat2(m_cs), sat2(m_cd)};
  endfunction

  // Reference classification straight from the word/position rules
  function automatic logic [13:0] classify(logic [7:0] rx, logic [3:0] p);
    logic [7:0] w;
    logic [1:0] s;
    int pos;
    w   = rx;
    pos = int'(p[2:0]);
    if (pos == 0 && !p[3]) s = 2'd0;
    else if (pos != 0 && p[3]) begin
      w[pos-1] = ~w[pos-1];
      s = 2'd1;
    end else if (p[3]) begin
      w[7] = ~w[7];
      s = 2'd2;
    end else s = 2'd3;
    return {w, w[6], w[5], w[4], w[2], s};
  endfunction

  task automatic tick();
    logic acc;
    logic [13:0] r;
    acc = in_valid && (!m_valid || out_ready);
    r = classify(palabra_rx, pos_error);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_word = 0; m_dato = 0; m_est = 0;
      m_cs = 0; m_cd = 0;
    end else begin
      if (acc) begin
        m_valid = 1'b1;
        {m_word, m_dato, m_est} = r;
      end else if (out_ready) m_valid = 1'b0;
      if (clr_cnt) begin
        m_cs = 0; m_cd = 0;
      end else if (acc) begin
        if (r[1:0] == 2'd1 || r[1:0] == 2'd2) m_cs++;
        else if (r[1:0] == 2'd3) m_cd++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; palabra_rx = 8'hff; pos_error = 4'b0011;
    tick(); tick();
    n_tot++;
    if (got_big !== 31'd0)
      $display("FAIL reset_out: got %h exp 0", got_big);
    else n_pass++;
    n_tot++;
    if (got_small !== 19'd0)
      $display("FAIL reset_small: got %h exp 0", got_small);
    else n_pass++;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_tot++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_in_ready: got %b exp 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [7:0] rxs [4] = '{8'h00, 8'h10, 8'h80, 8'h5a};
    logic [3:0] ps  [4] = '{4'b0000, 4'b1101, 4'b1000, 4'b0011};
    logic [1:0] es  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [7:0] ws  [4] = '{8'h00, 8'h00, 8'h00, 8'h5a};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; palabra_rx = rxs[i]; pos_error = ps[i];
      tick();
      n_tot++;
      if (got_big !== exp_big())
        $display("FAIL directed_%0d: got %h exp %h", i, got_big, exp_big());
      else n_pass++;
      n_tot++;
      if ({palabra_corr, estado_err} !== {ws[i], es[i]})
        $display("FAIL directed_lit_%0d: got %h/%b exp %h/%b", i,
                 palabra_corr, estado_err, ws[i], es[i]);
      else n_pass++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int cs0;
    logic [7:0] held;
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    cs0 = m_cs;
    in_valid = 1'b1; out_ready = 1'b0;
    palabra_rx = 8'h3c; pos_error = 4'b1101;
    tick();
    held = palabra_corr;
    for (int i = 0; i < 3; i++) begin
      palabra_rx = 8'($urandom);
      pos_error = 4'b1110;
      #1;
      n_tot++;
      if (in_ready !== 1'b0)
        $display("FAIL bp_in_ready_%0d: got %b exp 0", i, in_ready);
      else n_pass++;
      tick();
      n_tot++;
      if (got_big !== exp_big() || palabra_corr !== held)
        $display("FAIL bp_hold_%0d: got %h exp %h", i, got_big, exp_big());
      else n_pass++;
    end
    n_tot++;
    if (cnt_simple !== sat8(cs0 + 1))
      $display("FAIL bp_count: got %0d exp %0d", cnt_simple, sat8(cs0 + 1));
    else n_pass++;
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    clr_cnt = 1'b1; in_valid = 1'b0;
    tick();
    clr_cnt = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; pos_error = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      palabra_rx = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    n_tot++;
    if (s_cnt_doble !== 2'd3 || cnt_doble !== 8'd5)
      $display("FAIL saturation: got %0d/%0d exp 3/5", s_cnt_doble, cnt_doble);
    else n_pass++;
    n_tot++;
    if (got_small !== exp_small())
      $display("FAIL sat_small: got %h exp %h", got_small, exp_small());
    else n_pass++;
  endtask

  task automatic test_clr_accept();
    in_valid = 1'b1; pos_error = 4'b1101; palabra_rx = 8'h55; clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0; in_valid = 1'b0;
    n_tot++;
    if ({cnt_simple, cnt_doble, out_valid, estado_err} !== {16'd0, 1'b1, 2'b01})
      $display("FAIL clr_accept: got %0d/%0d/%b/%b exp 0/0/1/01",
               cnt_simple, cnt_doble, out_valid, estado_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; pos_error = 4'b0011; palabra_rx = 8'ha5; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    n_tot++;
    if (got_big !== 31'd0)
      $display("FAIL reset_mid: got %h exp 0", got_big);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid   = 1'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      palabra_rx = 8'($urandom);
      pos_error  = 4'($urandom);
      clr_cnt    = ($urandom_range(0, 31) == 0);
      #1;
      n_tot++;
      if (in_ready !== (!m_valid || out_ready))
        $display("FAIL rnd_in_ready_%0d: got %b exp %b", i, in_ready,
                 (!m_valid || out_ready));
      else n_pass++;
      tick();
      n_tot++;
      if (got_big !== exp_big() || got_small !== exp_small())
        $display("FAIL rnd_out_%0d: got %h/%h exp %h/%h", i, got_big,
                 got_small, exp_big(), exp_small());
      else n_pass++;
    end
    in_valid = 1'b0; clr_cnt = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_saturation();
    test_clr_accept();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
